// File: rtl/sprite_line_scheduler_if.sv
// Sprite ROM request/response channel. The scheduler drives the request
// fields and holds them stable until the ROM returns a one-cycle valid pulse
// with the matching row byte.
interface sprite_line_scheduler_if;
    logic       rom_req;
    logic [3:0] rom_sprite_id;
    logic [1:0] rom_orient;
    logic [2:0] rom_line;
    logic       rom_valid;
    logic [7:0] rom_data;

    modport master (
        output rom_req,
        output rom_sprite_id,
        output rom_orient,
        output rom_line,
        input  rom_valid,
        input  rom_data
    );

    modport slave (
        input  rom_req,
        input  rom_sprite_id,
        input  rom_orient,
        input  rom_line,
        output rom_valid,
        output rom_data
    );
endinterface

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite fetch scheduler. At the first blanking pixel it scans
// the entity slots for sprites whose tile row covers the next visible line,
// fetches one ROM row per hit into a shadow table, and at pixel 0 of the
// following line copies the shadow table to the committed line_* outputs
// used by the pixel mux.
module sprite_line_scheduler #(
    parameter int NUM_ENT  = 9,
    parameter int MAX_SPR  = 4,
    parameter int H_FETCH  = 640,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525,
    parameter int TILE_PX  = 40
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [9:0]              counter_H,
    input  logic [9:0]              counter_V,
    input  logic [14*NUM_ENT-1:0]   entities,
    sprite_line_scheduler_if.master rom,
    output logic [MAX_SPR-1:0]      line_valid,
    output logic [4*MAX_SPR-1:0]    line_col,
    output logic [8*MAX_SPR-1:0]    line_data,
    output logic                    overflow,
    output logic                    late
);

    localparam int SLOT_W  = $clog2(NUM_ENT);
    localparam int ENT_W   = $clog2(MAX_SPR + 1);
    localparam int UPSCALE = TILE_PX / 8;

    localparam logic [9:0]        H_FETCH_V   = 10'(H_FETCH);
    localparam logic [9:0]        V_ACTIVE_V  = 10'(V_ACTIVE);
    localparam logic [9:0]        V_LAST_V    = 10'(V_TOTAL - 1);
    localparam logic [9:0]        TILE_PX_V   = 10'(TILE_PX);
    localparam logic [9:0]        UPSCALE_V   = 10'(UPSCALE);
    localparam logic [SLOT_W-1:0] LAST_SLOT_V = SLOT_W'(NUM_ENT - 1);
    localparam logic [ENT_W-1:0]  MAX_SPR_V   = ENT_W'(MAX_SPR);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FETCH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state_r, state_nxt_s;

    logic [SLOT_W-1:0]    slot_ptr_r,   slot_ptr_nxt_s;
    logic [ENT_W-1:0]     entry_ptr_r,  entry_ptr_nxt_s;
    logic [3:0]           row_r,        row_nxt_s;
    logic [2:0]           lidx_r,       lidx_nxt_s;
    logic [3:0]           fetch_col_r,  fetch_col_nxt_s;

    logic [MAX_SPR-1:0]   sh_valid_r,   sh_valid_nxt_s;
    logic [4*MAX_SPR-1:0] sh_col_r,     sh_col_nxt_s;
    logic [8*MAX_SPR-1:0] sh_data_r,    sh_data_nxt_s;
    logic                 sh_ovf_r,     sh_ovf_nxt_s;

    logic                 rom_req_r,    rom_req_nxt_s;
    logic [3:0]           rom_id_r,     rom_id_nxt_s;
    logic [1:0]           rom_orient_r, rom_orient_nxt_s;
    logic [2:0]           rom_line_r,   rom_line_nxt_s;

    logic [MAX_SPR-1:0]   line_valid_r, line_valid_nxt_s;
    logic [4*MAX_SPR-1:0] line_col_r,   line_col_nxt_s;
    logic [8*MAX_SPR-1:0] line_data_r,  line_data_nxt_s;
    logic                 overflow_r,   overflow_nxt_s;
    logic                 late_r,       late_nxt_s;

    logic [9:0]  next_v_s;
    logic [3:0]  row_s;
    logic [2:0]  lidx_s;
    logic        commit_s;
    logic        last_slot_s;
    logic [13:0] ent_s [NUM_ENT];
    logic [13:0] cur_ent_s;
    logic [3:0]  cur_id_s;
    logic [1:0]  cur_orient_s;
    logic [7:0]  cur_tile_s;
    logic        hit_s;

    genvar g;
    generate
        for (g = 0; g < NUM_ENT; g++) begin : g_ent
            assign ent_s[g] = entities[14*g +: 14];
        end
    endgenerate

    // Line about to be drawn, its tile row and the sprite row inside that tile.
    always_comb begin
        if (counter_V == V_LAST_V) begin
            next_v_s = 10'd0;
        end else begin
            next_v_s = counter_V + 10'd1;
        end
        row_s  = 4'(next_v_s / TILE_PX_V);
        lidx_s = 3'((next_v_s % TILE_PX_V) / UPSCALE_V);
    end

    // Decode of the slot currently under the scan pointer.
    always_comb begin
        cur_ent_s    = ent_s[slot_ptr_r];
        cur_id_s     = cur_ent_s[13:10];
        cur_orient_s = cur_ent_s[9:8];
        cur_tile_s   = cur_ent_s[7:0];
        // Tiles 192 and up sit below the visible area and never match.
        hit_s        = (cur_id_s != 4'hF) && (cur_tile_s < 8'd192) &&
                       (cur_tile_s[7:4] == row_r);
        commit_s     = (counter_H == 10'd0);
        last_slot_s  = (slot_ptr_r == LAST_SLOT_V);
    end

    // Next-state and datapath update; the commit point overrides every state.
    always_comb begin
        state_nxt_s      = state_r;
        slot_ptr_nxt_s   = slot_ptr_r;
        entry_ptr_nxt_s  = entry_ptr_r;
        row_nxt_s        = row_r;
        lidx_nxt_s       = lidx_r;
        fetch_col_nxt_s  = fetch_col_r;
        sh_valid_nxt_s   = sh_valid_r;
        sh_col_nxt_s     = sh_col_r;
        sh_data_nxt_s    = sh_data_r;
        sh_ovf_nxt_s     = sh_ovf_r;
        rom_req_nxt_s    = rom_req_r;
        rom_id_nxt_s     = rom_id_r;
        rom_orient_nxt_s = rom_orient_r;
        rom_line_nxt_s   = rom_line_r;
        line_valid_nxt_s = line_valid_r;
        line_col_nxt_s   = line_col_r;
        line_data_nxt_s  = line_data_r;
        overflow_nxt_s   = overflow_r;
        late_nxt_s       = late_r;

        if (commit_s) begin
            // Publish the shadow table; any outstanding ROM response is dropped.
            line_valid_nxt_s = sh_valid_r;
            line_col_nxt_s   = sh_col_r;
            line_data_nxt_s  = sh_data_r;
            overflow_nxt_s   = sh_ovf_r;
            late_nxt_s       = (state_r != ST_IDLE) && (state_r != ST_DONE);
            rom_req_nxt_s    = 1'b0;
            state_nxt_s      = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (counter_H == H_FETCH_V) begin
                        // Cleared even for blank lines so they commit empty.
                        sh_valid_nxt_s  = {MAX_SPR{1'b0}};
                        sh_col_nxt_s    = {(4*MAX_SPR){1'b0}};
                        sh_data_nxt_s   = {(8*MAX_SPR){1'b0}};
                        sh_ovf_nxt_s    = 1'b0;
                        slot_ptr_nxt_s  = {SLOT_W{1'b0}};
                        entry_ptr_nxt_s = {ENT_W{1'b0}};
                        if (next_v_s < V_ACTIVE_V) begin
                            row_nxt_s   = row_s;
                            lidx_nxt_s  = lidx_s;
                            state_nxt_s = ST_SCAN;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (hit_s && (entry_ptr_r < MAX_SPR_V)) begin
                        rom_req_nxt_s    = 1'b1;
                        rom_id_nxt_s     = cur_id_s;
                        rom_orient_nxt_s = cur_orient_s;
                        rom_line_nxt_s   = lidx_r;
                        fetch_col_nxt_s  = cur_tile_s[3:0];
                        state_nxt_s      = ST_FETCH;
                    end else begin
                        if (hit_s) begin
                            sh_ovf_nxt_s = 1'b1;
                        end else begin
                            sh_ovf_nxt_s = sh_ovf_r;
                        end
                        if (last_slot_s) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            slot_ptr_nxt_s = slot_ptr_r + SLOT_W'(1);
                            state_nxt_s    = ST_SCAN;
                        end
                    end
                end
                ST_FETCH: begin
                    if (rom.rom_valid) begin
                        for (int i = 0; i < MAX_SPR; i++) begin
                            if (entry_ptr_r == ENT_W'(i)) begin
                                sh_valid_nxt_s[i]       = 1'b1;
                                sh_col_nxt_s[4*i +: 4]  = fetch_col_r;
                                sh_data_nxt_s[8*i +: 8] = rom.rom_data;
                            end else begin
                                sh_valid_nxt_s[i] = sh_valid_r[i];
                            end
                        end
                        entry_ptr_nxt_s = entry_ptr_r + ENT_W'(1);
                        rom_req_nxt_s   = 1'b0;
                        if (last_slot_s) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            slot_ptr_nxt_s = slot_ptr_r + SLOT_W'(1);
                            state_nxt_s    = ST_SCAN;
                        end
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_DONE;
                end
                default: begin
                    rom_req_nxt_s = 1'b0;
                    state_nxt_s   = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Scan pointers, shadow table, ROM request and committed line registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_ptr_r   <= {SLOT_W{1'b0}};
            entry_ptr_r  <= {ENT_W{1'b0}};
            row_r        <= 4'd0;
            lidx_r       <= 3'd0;
            fetch_col_r  <= 4'd0;
            sh_valid_r   <= {MAX_SPR{1'b0}};
            sh_col_r     <= {(4*MAX_SPR){1'b0}};
            sh_data_r    <= {(8*MAX_SPR){1'b0}};
            sh_ovf_r     <= 1'b0;
            rom_req_r    <= 1'b0;
            rom_id_r     <= 4'd0;
            rom_orient_r <= 2'd0;
            rom_line_r   <= 3'd0;
            line_valid_r <= {MAX_SPR{1'b0}};
            line_col_r   <= {(4*MAX_SPR){1'b0}};
            line_data_r  <= {(8*MAX_SPR){1'b0}};
            overflow_r   <= 1'b0;
            late_r       <= 1'b0;
        end else begin
            slot_ptr_r   <= slot_ptr_nxt_s;
            entry_ptr_r  <= entry_ptr_nxt_s;
            row_r        <= row_nxt_s;
            lidx_r       <= lidx_nxt_s;
            fetch_col_r  <= fetch_col_nxt_s;
            sh_valid_r   <= sh_valid_nxt_s;
            sh_col_r     <= sh_col_nxt_s;
            sh_data_r    <= sh_data_nxt_s;
            sh_ovf_r     <= sh_ovf_nxt_s;
            rom_req_r    <= rom_req_nxt_s;
            rom_id_r     <= rom_id_nxt_s;
            rom_orient_r <= rom_orient_nxt_s;
            rom_line_r   <= rom_line_nxt_s;
            line_valid_r <= line_valid_nxt_s;
            line_col_r   <= line_col_nxt_s;
            line_data_r  <= line_data_nxt_s;
            overflow_r   <= overflow_nxt_s;
            late_r       <= late_nxt_s;
        end
    end

    assign rom.rom_req       = rom_req_r;
    assign rom.rom_sprite_id = rom_id_r;
    assign rom.rom_orient    = rom_orient_r;
    assign rom.rom_line      = rom_line_r;
    assign line_valid        = line_valid_r;
    assign line_col          = line_col_r;
    assign line_data         = line_data_r;
    assign overflow          = overflow_r;
    assign late              = late_r;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Self-checking bench for sprite_line_scheduler: directed scenarios plus
// randomized lines checked against a per-line reference model.
module tb_sprite_line_scheduler;

    localparam int NUM_ENT = 9;
    localparam int MAX_SPR = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [9:0]             counter_H;
    logic [9:0]             counter_V;
    logic [14*NUM_ENT-1:0]  entities;
    logic [MAX_SPR-1:0]     line_valid;
    logic [4*MAX_SPR-1:0]   line_col;
    logic [8*MAX_SPR-1:0]   line_data;
    logic                   overflow;
    logic                   late;

    sprite_line_scheduler_if rom ();

    sprite_line_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .counter_H  (counter_H),
        .counter_V  (counter_V),
        .entities   (entities),
        .rom        (rom),
        .line_valid (line_valid),
        .line_col   (line_col),
        .line_data  (line_data),
        .overflow   (overflow),
        .late       (late)
    );

    always #5 clk = ~clk;

    logic [13:0] ent [NUM_ENT];
    int n_tests = 0;
    int n_fail  = 0;

    // ROM responder configuration and reference-model expectations
    bit                 rom_dead = 1'b0;
    int                 rom_lat  = 1;
    int                 req_cnt  = 0;
    int                 exp_n    = 0;
    int                 exp_reqs = 0;
    logic [3:0]         exp_id  [MAX_SPR];
    logic [1:0]         exp_or  [MAX_SPR];
    logic [7:0]         exp_dat [MAX_SPR];
    logic [2:0]         exp_ln;
    logic [MAX_SPR-1:0] exp_valid;
    logic [15:0]        exp_col;
    logic [31:0]        exp_data;
    logic               exp_ovf;
    logic               exp_late;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_entities();
        for (int i = 0; i < NUM_ENT; i++) entities[14*i +: 14] = ent[i];
    endtask

    task automatic clear_entities();
        for (int i = 0; i < NUM_ENT; i++) ent[i] = {4'hF, 2'b00, 8'h00};
    endtask

    // Reference model: which slots should be fetched for counter_V = v, and
    // what the committed table looks like after the pixel-0 commit.
    task automatic build_model(input int v);
        int nv, row, hits;
        logic [3:0] id;
        logic [7:0] tile;
        nv = (v == 524) ? 0 : v + 1;
        exp_n = 0; hits = 0;
        exp_valid = '0; exp_col = '0; exp_data = '0; exp_ln = 3'd0;
        if (nv < 480) begin
            row    = nv / 40;
            exp_ln = 3'((nv % 40) / 5);
            for (int s = 0; s < NUM_ENT; s++) begin
                id   = ent[s][13:10];
                tile = ent[s][7:0];
                if (id != 4'hF && int'(tile) < 192 && int'(tile) / 16 == row) begin
                    hits++;
                    if (exp_n < MAX_SPR) begin
                        exp_id[exp_n]  = id;
                        exp_or[exp_n]  = ent[s][9:8];
                        exp_dat[exp_n] = 8'($urandom);
                        exp_valid[exp_n] = 1'b1;
                        exp_col[4*exp_n +: 4]  = tile[3:0];
                        exp_data[8*exp_n +: 8] = exp_dat[exp_n];
                        exp_n++;
                    end
                end
            end
        end
        if (rom_dead) begin
            exp_reqs  = (exp_n > 0) ? 1 : 0;
            exp_late  = (exp_n > 0);
            exp_valid = '0; exp_col = '0; exp_data = '0;
            exp_ovf   = 1'b0;
        end else begin
            exp_reqs = exp_n;
            exp_late = 1'b0;
            exp_ovf  = (hits > MAX_SPR);
        end
    endtask

    // One blanking interval (H=640..799) followed by the pixel-0 commit.
    task automatic run_line(input int v, input string tag);
        load_entities();
        counter_V = 10'(v);
        build_model(v);
        req_cnt = 0;
        for (int h = 640; h < 800; h++) begin
            @(negedge clk);
            counter_H = 10'(h);
        end
        @(negedge clk);
        counter_H = 10'd0;
        @(negedge clk);
        counter_H = 10'd1;
        check_eq({tag, ".valid"}, line_valid, exp_valid);
        check_eq({tag, ".col"},   line_col,   exp_col);
        check_eq({tag, ".data"},  line_data,  exp_data);
        check_eq({tag, ".ovf"},   overflow,   exp_ovf);
        check_eq({tag, ".late"},  late,       exp_late);
        check_eq({tag, ".reqs"},  req_cnt,    exp_reqs);
        check_eq({tag, ".req_low"}, rom.rom_req, 1'b0);
    endtask

    // ROM responder: checks each new request and answers after rom_lat clocks.
    initial begin
        logic prev_req;
        int   wait_cnt;
        int   idx;
        rom.rom_valid = 1'b0;
        rom.rom_data  = 8'h00;
        prev_req = 1'b0;
        wait_cnt = 0;
        idx      = 0;
        forever begin
            @(negedge clk);
            rom.rom_valid = 1'b0;
            if (rom.rom_req === 1'b1) begin
                if (!prev_req) begin
                    req_cnt++;
                    idx      = req_cnt - 1;
                    wait_cnt = rom_lat;
                    if (idx < exp_n) begin
                        check_eq("req_id",     rom.rom_sprite_id, exp_id[idx]);
                        check_eq("req_orient", rom.rom_orient,    exp_or[idx]);
                        check_eq("req_line",   rom.rom_line,      exp_ln);
                    end
                end
                if (!rom_dead) begin
                    if (wait_cnt == 0) begin
                        rom.rom_valid = 1'b1;
                        rom.rom_data  = (idx < exp_n) ? exp_dat[idx] : 8'h00;
                        wait_cnt      = -1;
                    end else if (wait_cnt > 0) begin
                        wait_cnt--;
                    end
                end
            end
            prev_req = rom.rom_req;
        end
    end

    initial begin
        int tr;
        reset     = 1'b0;
        counter_H = 10'd1;
        counter_V = 10'd0;
        clear_entities();
        load_entities();
        repeat (3) @(negedge clk);
        check_eq("rst.valid", line_valid, 4'b0000);
        check_eq("rst.data",  line_data,  32'h0);
        check_eq("rst.col",   line_col,   16'h0);
        check_eq("rst.ovf",   overflow,   1'b0);
        check_eq("rst.late",  late,       1'b0);
        check_eq("rst.req",   rom.rom_req, 1'b0);
        check_eq("rst.id",    rom.rom_sprite_id, 4'h0);
        reset = 1'b1;
        @(negedge clk);

        // Single sprite, tile row 2 line 0 (next line 80)
        clear_entities();
        ent[0] = {4'h2, 2'b01, 8'h23};
        rom_lat = 2;
        run_line(79, "t1");
        check_eq("t1.valid_k", line_valid, 4'b0001);
        check_eq("t1.col_k",   line_col[3:0], 4'h3);

        // Asynchronous reset while a request is outstanding
        rom_dead = 1'b1;
        load_entities();
        counter_V = 10'd79;
        build_model(79);
        req_cnt = 0;
        for (int h = 640; h < 660; h++) begin
            @(negedge clk);
            counter_H = 10'(h);
        end
        check_eq("t5.req_pre", rom.rom_req, 1'b1);
        #2 reset = 1'b0;
        #1;
        check_eq("t5.req",   rom.rom_req, 1'b0);
        check_eq("t5.valid", line_valid,  4'b0000);
        check_eq("t5.data",  line_data,   32'h0);
        check_eq("t5.col",   line_col,    16'h0);
        check_eq("t5.id",    rom.rom_sprite_id, 4'h0);
        @(negedge clk);
        reset     = 1'b1;
        counter_H = 10'd1;
        rom_dead  = 1'b0;
        run_line(79, "t5b");

        // Six hits on row 1 line 1: four fetched, overflow
        clear_entities();
        for (int i = 0; i < 6; i++) ent[i] = {4'(i + 1), 2'(i), 4'h1, 4'(i + 2)};
        rom_lat = 1;
        run_line(45, "t2");
        check_eq("t2.valid_k", line_valid, 4'b1111);
        check_eq("t2.ovf_k",   overflow,   1'b1);

        // ROM never answers: fetch cut off at commit
        clear_entities();
        ent[0] = {4'h2, 2'b01, 8'h23};
        rom_dead = 1'b1;
        run_line(79, "t3");
        check_eq("t3.late_k", late, 1'b1);
        rom_dead = 1'b0;

        // Last visible line, blank line, frame wrap
        clear_entities();
        ent[0] = {4'h3, 2'b10, 8'hB5};
        ent[1] = {4'h4, 2'b11, 8'h05};
        run_line(478, "t4a");
        run_line(479, "t4b");
        run_line(524, "t4c");

        // Tile below the screen never hits
        clear_entities();
        ent[0] = {4'h1, 2'b00, 8'hC0};
        run_line(0,   "t6a");
        run_line(300, "t6b");
        run_line(478, "t6c");

        // Randomized lines
        for (int n = 0; n < 24; n++) begin
            int v;
            v  = $urandom_range(0, 524);
            tr = ((v == 524) ? 0 : v + 1) / 40;
            rom_lat  = $urandom_range(0, 5);
            rom_dead = ($urandom_range(0, 7) == 0);
            for (int s = 0; s < NUM_ENT; s++) begin
                ent[s][13:10] = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
                ent[s][9:8]   = 2'($urandom);
                ent[s][7:0]   = ($urandom_range(0, 2) == 0) ? 8'($urandom)
                                                            : {4'(tr), 4'($urandom)};
            end
            run_line(v, "rnd");
            rom_dead = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
